// File: rtl/mdio_master.sv
// Clause 22 MDIO initiator: generates MDC and shifts read/write frames over MDIO.
// Latency: (PREAMBLE_LEN+32)*2*CLK_DIV+1 clk from acceptance to resp_valid (MDIO_PREAMBLE_SUPPRESS_EN adds no_pre).
// Backpressure: req_ready is high only in IDLE and in the one-cycle DONE slot; one frame in flight.
module mdio_master #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  logic        no_pre,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err
);

    localparam int CNT_MAX = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
    } state_t;

    state_t          state, state_nxt, state_succ;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt, bit_last;
    logic [DW-1:0]   div_cnt;
    logic [31:0]     frame_sr;
    logic [31:0]     frame_new;
    logic [15:0]     rd_sr;
    logic            wr_q;
    logic            err_acc;
    logic            mdio_q;
    logic            skip_pre;
    logic            fire;
    logic            active;
    logic            div_last;
    logic            rise;
    logic            bit_end;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign skip_pre = no_pre;
`else
    assign skip_pre = 1'b0;
`endif

    assign req_ready = (state == S_IDLE) || (state == S_DONE);
    assign fire      = req_valid && req_ready;
    assign active    = (state != S_IDLE) && (state != S_DONE);
    assign div_last  = (div_cnt == DIV_LAST);
    // mdc doubles as the half-period phase: low half then high half of each bit
    assign rise      = active && !mdc && div_last;
    assign bit_end   = active &&  mdc && div_last;

    // Everything after the preamble; TA/DATA slots of a read are placeholders (line released)
    assign frame_new = {2'b01,
                        req_write ? 2'b01 : 2'b10,
                        req_phyad,
                        req_regad,
                        2'b10,
                        req_write ? req_wdata : 16'h0000};

    always_comb begin
        bit_last   = '0;
        state_succ = S_IDLE;
        case (state)
            S_PRE:   begin bit_last = PRE_LAST; state_succ = S_ST;    end
            S_ST:    begin bit_last = CW'(1);   state_succ = S_OP;    end
            S_OP:    begin bit_last = CW'(1);   state_succ = S_PHYAD; end
            S_PHYAD: begin bit_last = CW'(4);   state_succ = S_REGAD; end
            S_REGAD: begin bit_last = CW'(4);   state_succ = S_TA;    end
            S_TA:    begin bit_last = CW'(1);   state_succ = S_DATA;  end
            S_DATA:  begin bit_last = CW'(15);  state_succ = S_DONE;  end
            default: begin bit_last = '0;       state_succ = S_IDLE;  end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        case (state)
            S_IDLE, S_DONE: begin
                bit_cnt_nxt = '0;
                if (fire) state_nxt = skip_pre ? S_ST : S_PRE;
                else      state_nxt = S_IDLE;
            end
            default: begin
                if (bit_end) begin
                    if (bit_cnt == bit_last) begin
                        state_nxt   = state_succ;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            mdio_q     <= 1'b1;
            div_cnt    <= '0;
            frame_sr   <= '0;
            rd_sr      <= '0;
            wr_q       <= 1'b0;
            err_acc    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            mdio_q     <= mdio_i;
            if (fire) begin
                div_cnt <= '0;
                mdc     <= 1'b0;
                wr_q    <= req_write;
                err_acc <= 1'b0;
                rd_sr   <= '0;
                mdio_oe <= 1'b1;
                if (skip_pre) begin
                    mdio_o   <= frame_new[31];
                    frame_sr <= {frame_new[30:0], 1'b0};
                end else begin
                    mdio_o   <= 1'b1;
                    frame_sr <= frame_new;
                end
            end else if (active) begin
                div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                if (rise) begin
                    mdc <= 1'b1;
                    // PHY changes the line just after MDC rises, so the value held in mdio_q is stable
                    if (!wr_q && state == S_TA && bit_cnt == CW'(1)) err_acc <= mdio_q;
                    if (!wr_q && state == S_DATA) rd_sr <= {rd_sr[14:0], mdio_q};
                end
                if (bit_end) begin
                    mdc <= 1'b0;
                    if (state_nxt == S_DONE) begin
                        mdio_oe    <= 1'b0;
                        mdio_o     <= 1'b1;
                        resp_valid <= 1'b1;
                        resp_rdata <= wr_q ? 16'h0000 : rd_sr;
                        resp_err   <= wr_q ? 1'b0 : err_acc;
                    end else if (state_nxt == S_PRE) begin
                        mdio_o <= 1'b1;
                    end else begin
                        if (!wr_q && (state_nxt == S_TA || state_nxt == S_DATA)) begin
                            mdio_o  <= 1'b1;
                            mdio_oe <= 1'b0;
                        end else begin
                            mdio_o  <= frame_sr[31];
                            mdio_oe <= 1'b1;
                        end
                        frame_sr <= {frame_sr[30:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
